// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle control path: ALU ops, opcodes, write-back/PC selects, FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4     = 2'd0,
        PC_ALU       = 2'd1,
        PC_ALU_ALIGN = 2'd2
    } pc_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_OPIMM  = 4'd1,
        CL_LUI    = 4'd2,
        CL_AUIPC  = 4'd3,
        CL_JAL    = 4'd4,
        CL_JALR   = 4'd5,
        CL_BRANCH = 4'd6,
        CL_LOAD   = 4'd7,
        CL_STORE  = 4'd8,
        CL_FENCE  = 4'd9,
        CL_SYS    = 4'd10,
        CL_BAD    = 4'd11
    } cls_e;

    // alt selects SUB/SRA; callers only set it where the encoding allows it.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate extractor: sign-extended I/S/B/U/J immediate selected by opcode.
// Purely combinational, zero latency; no handshake.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] w_opc;
    assign w_opc = instr[6:0];

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (w_opc)
            OPC_STORE:        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:       imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0};
            OPC_LUI,
            OPC_AUIPC:        imm = {instr[31:12], 12'h000};
            OPC_JAL:          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0};
            OPC_OP:           imm = 32'h0000_0000;
            default:          imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the RV32I multicycle datapath: FETCH/DECODE/EXEC[/MEM]/WB per instruction.
// 4 cycles per non-memory instruction, 5 for loads/stores with zero-wait acks; stalls indefinitely on instr_ack/mem_ack.
module multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL   = 2'd0,
    parameter bit         TRAP_ON_SYSTEM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        br_cond,
    output logic [3:0]  alu_sel,
    output logic        mux_A_sel,
    output logic        mux_B_sel,
    output logic [31:0] imm_out,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [2:0]  state_dbg
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_instr;
    logic [31:0] r_imm;
    cls_e        r_cls;
    logic        r_taken;

    logic [31:0] w_imm;
    cls_e        w_cls;
    logic        w_trap;
    alu_op_e     w_alu;
    logic        w_mux_a;
    logic        w_mux_b;
    logic        w_rd_write;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    assign w_opc = r_instr[6:0];
    assign w_f3  = r_instr[14:12];
    assign w_f7  = r_instr[31:25];

    imm_gen u_imm_gen (
        .instr (r_instr),
        .imm   (w_imm)
    );

    // Classification doubles as the legality check: anything not matched stays CL_BAD.
    always_comb begin
        w_cls = CL_BAD;
        case (w_opc)
            OPC_OP:
                if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)))
                    w_cls = CL_R;
            OPC_OPIMM:
                if (w_f3 == 3'b001) begin
                    if (w_f7 == 7'h00) w_cls = CL_OPIMM;
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'h00 || w_f7 == 7'h20) w_cls = CL_OPIMM;
                end else begin
                    w_cls = CL_OPIMM;
                end
            OPC_LUI:    w_cls = CL_LUI;
            OPC_AUIPC:  w_cls = CL_AUIPC;
            OPC_JAL:    w_cls = CL_JAL;
            OPC_JALR:   if (w_f3 == 3'b000) w_cls = CL_JALR;
            OPC_BRANCH: if (w_f3 != 3'b010 && w_f3 != 3'b011) w_cls = CL_BRANCH;
            OPC_LOAD:   if (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) w_cls = CL_LOAD;
            OPC_STORE:  if (w_f3 <= 3'b010) w_cls = CL_STORE;
            OPC_FENCE:  if (w_f3 == 3'b000) w_cls = CL_FENCE;
            OPC_SYSTEM:
                if (r_instr[31:7] == 25'h000_0000 || r_instr[31:7] == 25'h000_2000)
                    w_cls = CL_SYS;
            default:    w_cls = CL_BAD;
        endcase
    end

    assign w_trap = (w_cls == CL_BAD) || (w_cls == CL_SYS && TRAP_ON_SYSTEM);

    always_comb begin
        w_alu   = ALU_ADD;
        w_mux_a = 1'b0;
        w_mux_b = 1'b0;
        case (r_cls)
            CL_R:      w_alu = alu_from_f3(w_f3, r_instr[30]);
            CL_OPIMM: begin
                w_alu   = alu_from_f3(w_f3, (w_f3 == 3'b101) && r_instr[30]);
                w_mux_b = 1'b1;
            end
            CL_LUI: begin
                w_alu   = ALU_PASS_B;
                w_mux_b = 1'b1;
            end
            CL_AUIPC, CL_JAL, CL_BRANCH: begin
                w_mux_a = 1'b1;
                w_mux_b = 1'b1;
            end
            CL_JALR, CL_LOAD, CL_STORE: w_mux_b = 1'b1;
            default: ;
        endcase
    end

    assign w_rd_write = (r_instr[11:7] != 5'd0) &&
                        (r_cls == CL_R || r_cls == CL_OPIMM || r_cls == CL_LUI ||
                         r_cls == CL_AUIPC || r_cls == CL_LOAD || r_cls == CL_JAL ||
                         r_cls == CL_JALR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= 32'h0000_0000;
            r_imm   <= 32'h0000_0000;
            r_cls   <= CL_FENCE;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH && instr_ack) r_instr <= instr;
            if (r_state == ST_DECODE) begin
                r_imm <= w_imm;
                r_cls <= w_cls;
            end
            if (r_state == ST_EXEC) r_taken <= br_cond;
        end
    end

    always_comb begin
        w_next    = r_state;
        instr_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_sel   = ALU_ADD;
        mux_A_sel = 1'b0;
        mux_B_sel = 1'b0;
        imm_out   = r_imm;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        illegal   = 1'b0;

        // ALU controls stay up through MEM/WB since the datapath result register is loaded in EXEC.
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            alu_sel   = w_alu;
            mux_A_sel = w_mux_a;
            mux_B_sel = w_mux_b;
        end

        case (r_state)
            ST_IDLE: begin
                pc_sel = RESET_PC_SEL;
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) w_next = ST_DECODE;
            end
            ST_DECODE: w_next = w_trap ? ST_TRAP : ST_EXEC;
            ST_EXEC:   w_next = (r_cls == CL_LOAD || r_cls == CL_STORE) ? ST_MEM : ST_WB;
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_cls == CL_STORE);
                if (mem_ack) w_next = ST_WB;
            end
            ST_WB: begin
                pc_we  = 1'b1;
                rf_we  = w_rd_write;
                if (r_cls == CL_LOAD)                         wb_sel = WB_MEM;
                else if (r_cls == CL_JAL || r_cls == CL_JALR) wb_sel = WB_PC4;
                if (r_cls == CL_JAL || (r_cls == CL_BRANCH && r_taken)) pc_sel = PC_ALU;
                else if (r_cls == CL_JALR)                              pc_sel = PC_ALU_ALIGN;
                w_next = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
                imm_out = 32'h0000_0000;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-decoded RV32I words, checks at posedge+1.
module tb_multicycle_ctrl;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_ack = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ack = 1'b0;
    logic        br_cond = 1'b0;
    logic        instr_req, mem_req, mem_we, mux_A_sel, mux_B_sel, rf_we, pc_we, illegal;
    logic [3:0]  alu_sel;
    logic [31:0] imm_out;
    logic [1:0]  wb_sel, pc_sel;
    logic [2:0]  state_dbg;
    logic [15:0] ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC_SEL(2'd0), .TRAP_ON_SYSTEM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .br_cond(br_cond),
        .alu_sel(alu_sel), .mux_A_sel(mux_A_sel), .mux_B_sel(mux_B_sel), .imm_out(imm_out),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    assign ctl = {instr_req, mem_req, mem_we, alu_sel, mux_A_sel, mux_B_sel,
                  rf_we, wb_sel, pc_we, pc_sel, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in DECODE; instr is poisoned afterwards so only the ack edge may capture.
    task automatic fetch(input logic [31:0] w);
        for (int i = 0; i < 20; i++) begin
            if (state_dbg == ST_FETCH) break;
            step();
        end
        chk("fetch_state", state_dbg, ST_FETCH);
        chk("fetch_req", instr_req, 1'b1);
        instr     = w;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        instr     = 32'h0000_007F;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Reset: everything quiet, IDLE.
        #2;
        chk("rst_ctl", ctl, 16'h0000);
        chk("rst_imm", imm_out, 32'h0);
        chk("rst_state", state_dbg, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_hold", state_dbg, ST_IDLE);
        step();
        chk("first_fetch", state_dbg, ST_FETCH);
        repeat (8) step();
        chk("fetch_wait_req", instr_req, 1'b1);
        chk("fetch_wait_ctl", ctl, 16'h8000);

        // ADD x3,x1,x2: FETCH=1 DECODE=2 EXEC=3 WB=4.
        fetch(32'h002081B3);
        chk("add_dec_pcwe", pc_we, 1'b0);
        chk("add_dec_req", instr_req, 1'b0);
        step();
        chk("add_ex_state", state_dbg, ST_EXEC);
        chk("add_ex_alu", alu_sel, ALU_ADD);
        chk("add_ex_ma", mux_A_sel, 1'b0);
        chk("add_ex_mb", mux_B_sel, 1'b0);
        chk("add_ex_pcwe", pc_we, 1'b0);
        step();
        chk("add_wb_pcwe", pc_we, 1'b1);
        chk("add_wb_rfwe", rf_we, 1'b1);
        chk("add_wb_wbsel", wb_sel, 2'd0);
        chk("add_wb_pcsel", pc_sel, 2'd0);
        step();
        chk("add_after_pcwe", pc_we, 1'b0);
        chk("add_after_state", state_dbg, ST_FETCH);

        // ADDI x1,x0,-1
        fetch(32'hFFF00093);
        step();
        chk("addi_imm", imm_out, 32'hFFFFFFFF);
        chk("addi_mb", mux_B_sel, 1'b1);
        chk("addi_alu", alu_sel, ALU_ADD);
        step();
        chk("addi_rfwe", rf_we, 1'b1);
        step();

        // ADDI x0,x0,0: no register write, PC still advances.
        fetch(32'h00000013);
        step();
        step();
        chk("nop_rfwe", rf_we, 1'b0);
        chk("nop_pcwe", pc_we, 1'b1);
        step();

        // SUB x3,x1,x2
        fetch(32'h402081B3);
        step();
        chk("sub_alu", alu_sel, ALU_SUB);
        step();
        step();

        // LW x5,8(x1), mem_ack arrives in the 4th MEM cycle.
        fetch(32'h0080A283);
        step();
        chk("lw_imm", imm_out, 32'h8);
        chk("lw_mb", mux_B_sel, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_req", mem_req, 1'b1);
            chk("lw_mem_we", mem_we, 1'b0);
            chk("lw_mem_pcwe", pc_we, 1'b0);
            step();
        end
        chk("lw_mem_req4", mem_req, 1'b1);
        chk("lw_alu_held", alu_sel, ALU_ADD);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("lw_wb_pcwe", pc_we, 1'b1);
        chk("lw_wb_wbsel", wb_sel, 2'd1);
        chk("lw_wb_rfwe", rf_we, 1'b1);
        chk("lw_wb_memreq", mem_req, 1'b0);
        step();

        // SW x5,8(x1), zero-wait: pc_we in cycle 5.
        fetch(32'h0050A423);
        step();
        chk("sw_imm", imm_out, 32'h8);
        step();
        chk("sw_mem_req", mem_req, 1'b1);
        chk("sw_mem_we", mem_we, 1'b1);
        chk("sw_mem_pcwe", pc_we, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sw_wb_pcwe", pc_we, 1'b1);
        chk("sw_wb_rfwe", rf_we, 1'b0);
        step();

        // BEQ -8 taken
        fetch(32'hFE000CE3);
        step();
        br_cond = 1'b1;
        chk("beq_imm", imm_out, 32'hFFFFFFF8);
        chk("beq_ma", mux_A_sel, 1'b1);
        chk("beq_mb", mux_B_sel, 1'b1);
        step();
        br_cond = 1'b0;
        chk("beq_t_pcsel", pc_sel, 2'd1);
        chk("beq_t_rfwe", rf_we, 1'b0);
        chk("beq_t_pcwe", pc_we, 1'b1);
        step();

        // BEQ -8 not taken
        fetch(32'hFE000CE3);
        step();
        step();
        chk("beq_n_pcsel", pc_sel, 2'd0);
        chk("beq_n_rfwe", rf_we, 1'b0);
        step();

        // JAL x1,+8
        fetch(32'h008000EF);
        step();
        chk("jal_imm", imm_out, 32'h8);
        chk("jal_ma", mux_A_sel, 1'b1);
        step();
        chk("jal_pcsel", pc_sel, 2'd1);
        chk("jal_wbsel", wb_sel, 2'd2);
        chk("jal_rfwe", rf_we, 1'b1);
        step();

        // MUL (funct7=1) is outside RV32I.
        fetch(32'h022081B3);
        step();
        chk("mul_trap", state_dbg, ST_TRAP);
        chk("mul_illegal", illegal, 1'b1);
        do_reset();
        chk("mul_recover", state_dbg, ST_FETCH);

        // Unknown opcode 0x7F: TRAP holds with only illegal set.
        fetch(32'h0000007F);
        step();
        repeat (5) step();
        chk("trap_state", state_dbg, ST_TRAP);
        chk("trap_ctl", ctl, 16'h0001);
        chk("trap_imm", imm_out, 32'h0);
        do_reset();
        chk("trap_recover", state_dbg, ST_FETCH);

        // Asynchronous reset mid-MEM.
        fetch(32'h0080A283);
        step();
        step();
        chk("arst_mem_req", mem_req, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_memreq_drop", mem_req, 1'b0);
        chk("arst_state", state_dbg, ST_IDLE);
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_idle", state_dbg, ST_IDLE);
        step();
        chk("arst_fetch", state_dbg, ST_FETCH);
        fetch(32'h002081B3);
        step();
        step();
        chk("arst_add_pcwe", pc_we, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style sequencer for the RV32I multicycle datapath, one instruction at a time.
- Fetches and latches each instruction, then generates the immediate.
- Drives the EX-stage controls (alu_sel, mux_A_sel, mux_B_sel), the memory handshake, and register-file/PC write-back.
- Sits between instruction/data memory and the EX stage, register file and PC register.

Parameters:
RESET_PC_SEL, 0, pc_sel value presented during IDLE (datapath PC reset value is owned by the PC register)
TRAP_ON_SYSTEM, 1, 1: ECALL/EBREAK enter TRAP; 0: treated as NOP

Ports:
clk  input  1  core clock
rst_n  input  1  reset; asynchronous, active-low
instr_req  output  1  instruction fetch request
instr_ack  input  1  fetch complete; instr valid this cycle
instr  input  32  fetched instruction word
mem_req  output  1  data memory request (loads/stores)
mem_we  output  1  1 = store, 0 = load; valid while mem_req=1
mem_ack  input  1  data access complete
br_cond  input  1  branch comparator result for current instr's funct3 (valid in EXEC)
alu_sel  output  4  ALU operation (package encoding)
mux_A_sel  output  1  ALU A source: 1 = pc, 0 = rs1 data
mux_B_sel  output  1  ALU B source: 1 = immediate, 0 = rs2 data
imm_out  output  32  sign-extended immediate of current instruction
rf_we  output  1  register-file write enable (single cycle)
wb_sel  output  2  write-back source: 0 ALU, 1 memory, 2 pc+4
pc_we  output  1  PC update enable (single cycle)
pc_sel  output  2  next PC: 0 pc+4, 1 ALU result, 2 ALU result & ~1
illegal  output  1  sticky; unsupported encoding seen
state_dbg  output  3  current state encoding

Behaviour:
- Async reset (rst_n=0): state=IDLE; instr/imm registers 0, taken flag 0; all outputs 0 (pc_sel=RESET_PC_SEL). Effect is immediate, including mid-handshake.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE -> FETCH unconditionally on the first clk after rst_n rises.
- FETCH:
  - instr_req=1 until instr_ack is sampled 1; instr is captured on that edge; -> DECODE.
  - instr_ack while instr_req=0 is ignored.
- DECODE (1 cycle):
  - Register imm by type: I, S, B (bit0=0), U (low 12 = 0), J (bit0=0).
  - Classify the opcode. Unknown opcode or bad funct3/funct7 -> TRAP.
- EXEC (1 cycle): drive alu_sel/mux_A_sel/mux_B_sel per class:
  - R: rs1 op rs2; SUB/SRA when funct7[5]=1.
  - OP-IMM: rs1 op imm; SRAI uses funct7[5].
  - LUI: PASS_B with imm.
  - AUIPC, JAL, BRANCH: ADD, A=pc, B=imm.
  - JALR, LOAD, STORE: ADD, A=rs1, B=imm.
  - br_cond is captured into the taken flag.
  - Next state: LOAD/STORE -> MEM; all others -> WB.
  - ALU controls stay held in MEM and WB (datapath result register is loaded in EXEC).
- MEM:
  - mem_req=1, mem_we=1 for STORE, until mem_ack is sampled 1; -> WB.
  - Wait length is unbounded.
- WB (1 cycle):
  - pc_we=1.
  - rf_we=1 for R/OP-IMM/LUI/AUIPC/LOAD/JAL/JALR, forced 0 when rd=x0.
  - wb_sel: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - pc_sel: 1 for JAL, or BRANCH with taken flag set; 2 for JALR; 0 otherwise.
  - Next state: FETCH.
- FENCE: NOP (no rf_we, pc+4).
- ECALL/EBREAK: TRAP if TRAP_ON_SYSTEM, else NOP.
- TRAP: illegal=1; all other outputs 0; held until reset.
- Latency with zero-wait acks (instr_req asserted to pc_we):
  - 4 cycles for non-memory instructions.
  - 5 cycles for loads and stores.

Decomposition:
Shared package rv32i_pkg holds:
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
- Opcode constants.
- wb_sel and pc_sel codes.
- State encoding.

Sub-module imm_gen (combinational, instr -> imm by type); its output is registered in DECODE.

Test Plan:
- Reset then release, instr_ack held 0 -> all outputs 0 during reset; state FETCH with instr_req=1 held indefinitely, no other activity.
- ADD x3,x1,x2 (0x002081B3), zero-wait ack -> EXEC alu_sel=0, muxA=0, muxB=0; WB rf_we=1, wb_sel=0, pc_sel=0; pc_we exactly 4 cycles after req.
- ADDI x1,x0,-1 (0xFFF00093) -> imm_out=0xFFFFFFFF, muxB=1; ADDI x0,x0,0 -> rf_we=0, pc_we=1.
- LW x5,8(x1) (0x0080A283), mem_ack delayed 3 cycles -> mem_req=1, mem_we=0 for 4 cycles; then WB wb_sel=1, rf_we=1; SW -> mem_we=1, rf_we=0.
- BEQ offset -8 (0xFE000CE3):
  - br_cond=1 -> imm_out=0xFFFFFFF8, muxA=1, pc_sel=1.
  - br_cond=0 -> pc_sel=0, rf_we=0.
- Opcode 0x7F -> TRAP, illegal=1 held; separately, rst_n=0 mid-MEM -> mem_req falls same cycle; restart from IDLE.
